eval_stack: RTL
===============

Name: eval_stack

Overview:
- Three-entry 16-bit evaluation stack (A = top, B, C) that sits directly upstream of the ALU.
- Sources the ALU's a/b/opcode inputs and writes the ALU result r back as the new top.
- Captures the ALU status outputs (cout, zero, error, compareVal) into a flags register.
- Accepts one stack command per handshake from the decode/control unit.

Parameters:
- WIDTH, 16, data width of stack entries and ALU operands.
- DEPTH, 3, number of stack entries; legal range 2..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd  in  3  stack command: 0 NOP, 1 PUSH, 2 POP, 3 ALU, 4 SWAP, 5 DUP, 6 CLRERR, 7 reserved.
- cmd_valid  in  1  cmd, push_data and op are valid.
- cmd_ready  out  1  block can accept a command this cycle.
- push_data  in  WIDTH  value for PUSH.
- op  in  4  ALU opcode, used with cmd=ALU.
- alu_a  out  WIDTH  registered; ALU operand a (= B).
- alu_b  out  WIDTH  registered; ALU operand b (= A).
- alu_opcode  out  4  registered ALU opcode.
- alu_r  in  WIDTH  ALU result.
- alu_cout, alu_zero, alu_error  in  1 each  ALU status.
- alu_cmp  in  2  ALU compareVal.
- top  out  WIDTH  current A.
- second  out  WIDTH  current B.
- count  out  3  number of valid entries, 0..DEPTH.
- flag_cout, flag_zero, flag_err  out  1 each  flags captured from the last ALU op.
- flag_cmp  out  2  compareVal captured from the last ALU op.
- stack_err  out  1  sticky underflow/overflow indicator.

Behaviour:
- Reset: all entries 0, count 0, FSM IDLE, alu_a/alu_b/alu_opcode 0, all flags 0, stack_err 0, cmd_ready 1.
- Reset is asynchronous. Asserting it mid-EXEC aborts the ALU op; no writeback occurs.
- Accept occurs on cmd_valid && cmd_ready.
- FSM IDLE:
  - cmd_ready = 1.
  - Non-ALU commands complete on the accept edge.
  - An accepted ALU command with count >= 2 loads alu_a <= B, alu_b <= A, alu_opcode <= op, then goes to EXEC.
- FSM EXEC (exactly one cycle):
  - cmd_ready = 0; the ALU evaluates combinationally.
  - At the end-of-cycle edge, capture flags from alu_* and return to IDLE.
  - If alu_error = 0: A <= alu_r, B <= C, C <= C, count <= count-1.
  - If alu_error = 1: stack unchanged; flag_err = 1.
- ALU latency: 2 edges from accept to updated top. Back-to-back throughput is one ALU op per 2 cycles.
- PUSH:
  - Shifts down (C <= B, B <= A, A <= push_data); count saturates at DEPTH.
  - When full, the bottom entry is discarded and stack_err is set.
- POP:
  - Shifts up (A <= B, B <= C); C is unchanged; count-1.
  - At count = 0: no change except stack_err is set.
- SWAP: exchanges A and B. Requires count >= 2; otherwise no-op and stack_err is set.
- DUP: pushes a copy of A. Requires count >= 1; otherwise stack_err is set. Full-stack handling is the same as PUSH.
- ALU with count < 2: accepted, no EXEC, stack unchanged, stack_err set, flags unchanged.
- CLRERR: clears stack_err and flag_err; stack untouched.
- NOP and reserved: accepted, no effect.
- Flags change only at EXEC writeback and on CLRERR; they hold between ALU ops.
- Width rules: no arithmetic in this block beyond count ±1; all data moves are full WIDTH.

Decomposition:
- Shared package eval_pkg: cmd encodings (CMD_NOP..CMD_CLRERR) and ALU opcode constants matching the ALU map (ALU_ADD = 4'h0, ALU_SUB = 4'h1).
- FSM state encoding: IDLE = 0, EXEC = 1.
- The entry-storage shift register is a natural sub-module, stack_regfile. The FSM, count and flags stay in eval_stack.
- The bench instantiates eval_stack together with the real ALU.

Test Plan:
- Reset, PUSH 0x0005, PUSH 0x0003, ALU ALU_ADD -> cmd_ready low 1 cycle; 2 edges after accept top = 0x0008, count = 1, flag_zero = 0, flag_cout = 0.
- PUSH 0x0003, PUSH 0x0005, ALU ALU_SUB -> top = 0xFFFE (B-A), count = 1. Then PUSH 0xFFFF, PUSH 0x0001, ALU_ADD -> top = 0x0000, flag_zero = 1, flag_cout = 1.
- Overflow: PUSH 1, 2, 3, 4 -> count = 3, top = 4, second = 3, stack_err = 1. Then CLRERR -> stack_err = 0, entries unchanged.
- Underflow: reset, POP -> count = 0, stack_err = 1. Then PUSH 7, ALU -> no EXEC, top = 7, count = 1.
- ALU error path: force alu_error = 1 via an opcode the ALU flags as an error -> stack unchanged (top/second keep their values), flag_err = 1, count unchanged.
- Reset asserted during EXEC -> on assertion count = 0, cmd_ready = 1, flags = 0; no writeback edge follows.

Source files
------------

// File: rtl/eval_pkg.sv
// Shared encodings for the evaluation stack: command codes, ALU opcodes,
// control FSM states and the entry-storage operations.
package eval_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_PUSH   = 3'd1,
    CMD_POP    = 3'd2,
    CMD_ALU    = 3'd3,
    CMD_SWAP   = 3'd4,
    CMD_DUP    = 3'd5,
    CMD_CLRERR = 3'd6,
    CMD_RSVD   = 3'd7
  } cmd_e;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    RF_HOLD = 3'd0,
    RF_PUSH = 3'd1,
    RF_POP  = 3'd2,
    RF_SWAP = 3'd3,
    RF_WB   = 3'd4
  } rf_op_e;

endpackage

// File: rtl/stack_regfile.sv
// Entry storage for the evaluation stack: entry 0 is the top (A), entry 1 is B.
// Performs one shift/swap/writeback operation per clock as selected by op_i.
module stack_regfile
  import eval_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  rf_op_e           op_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] second_o
);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];

  // Writeback is a pop whose new top is the ALU result; the bottom entry keeps its value.
  always_comb begin
    entries_d = entries_q;
    case (op_i)
      RF_PUSH: begin
        for (int i = 1; i < DEPTH; i++) entries_d[i] = entries_q[i-1];
        entries_d[0] = din_i;
      end
      RF_POP, RF_WB: begin
        for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
        if (op_i == RF_WB) entries_d[0] = din_i;
      end
      RF_SWAP: begin
        entries_d[0] = entries_q[1];
        entries_d[1] = entries_q[0];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  assign top_o    = entries_q[0];
  assign second_o = entries_q[1];

endmodule

// File: rtl/eval_stack.sv
// Evaluation stack feeding the ALU: accepts one command per handshake, runs ALU
// ops through a one-cycle EXEC state and writes the result back as the new top.
module eval_stack
  import eval_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout,
  input  logic             alu_zero,
  input  logic             alu_error,
  input  logic [1:0]       alu_cmp,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [2:0]       count,
  output logic             flag_cout,
  output logic             flag_zero,
  output logic             flag_err,
  output logic [1:0]       flag_cmp,
  output logic             stack_err
);

  localparam logic [2:0] FULL = 3'(DEPTH);

  state_e           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             fcout_q, fcout_d;
  logic             fzero_q, fzero_d;
  logic             ferr_q, ferr_d;
  logic [1:0]       fcmp_q, fcmp_d;
  logic             serr_q, serr_d;

  rf_op_e           rf_op;
  logic [WIDTH-1:0] rf_din;
  logic [WIDTH-1:0] top_w, second_w;

  stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .op_i    (rf_op),
    .din_i   (rf_din),
    .top_o   (top_w),
    .second_o(second_w)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    opcode_d  = opcode_q;
    fcout_d   = fcout_q;
    fzero_d   = fzero_q;
    ferr_d    = ferr_q;
    fcmp_d    = fcmp_q;
    serr_d    = serr_q;
    rf_op     = RF_HOLD;
    rf_din    = push_data;
    cmd_ready = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_e'(cmd))
            CMD_PUSH: begin
              rf_op = RF_PUSH;
              if (count_q == FULL) serr_d = 1'b1;
              else count_d = count_q + 3'd1;
            end
            CMD_POP: begin
              if (count_q == 3'd0) begin
                serr_d = 1'b1;
              end else begin
                rf_op   = RF_POP;
                count_d = count_q - 3'd1;
              end
            end
            CMD_ALU: begin
              if (count_q >= 3'd2) begin
                alu_a_d  = second_w;
                alu_b_d  = top_w;
                opcode_d = op;
                state_d  = ST_EXEC;
              end else begin
                serr_d = 1'b1;
              end
            end
            CMD_SWAP: begin
              if (count_q >= 3'd2) rf_op = RF_SWAP;
              else serr_d = 1'b1;
            end
            CMD_DUP: begin
              if (count_q == 3'd0) begin
                serr_d = 1'b1;
              end else begin
                rf_op  = RF_PUSH;
                rf_din = top_w;
                if (count_q == FULL) serr_d = 1'b1;
                else count_d = count_q + 3'd1;
              end
            end
            CMD_CLRERR: begin
              serr_d = 1'b0;
              ferr_d = 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        fcout_d = alu_cout;
        fzero_d = alu_zero;
        ferr_d  = alu_error;
        fcmp_d  = alu_cmp;
        // A faulting ALU op leaves the operands on the stack untouched.
        if (!alu_error) begin
          rf_op   = RF_WB;
          rf_din  = alu_r;
          count_d = count_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      opcode_q <= '0;
      fcout_q  <= 1'b0;
      fzero_q  <= 1'b0;
      ferr_q   <= 1'b0;
      fcmp_q   <= '0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      opcode_q <= opcode_d;
      fcout_q  <= fcout_d;
      fzero_q  <= fzero_d;
      ferr_q   <= ferr_d;
      fcmp_q   <= fcmp_d;
      serr_q   <= serr_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = opcode_q;
  assign top        = top_w;
  assign second     = second_w;
  assign count      = count_q;
  assign flag_cout  = fcout_q;
  assign flag_zero  = fzero_q;
  assign flag_err   = ferr_q;
  assign flag_cmp   = fcmp_q;
  assign stack_err  = serr_q;

endmodule
